// File: rtl/coll_pkg.sv
// Shared types for the collision scheduler: object record, sweep FSM states, index-width helper.
package coll_pkg;

  typedef struct packed {
    logic signed [7:0]  width;
    logic signed [7:0]  height;
    logic signed [31:0] pos_x;
    logic signed [31:0] pos_y;
    logic signed [23:0] vel_x;
    logic signed [23:0] vel_y;
    logic signed [15:0] u_x;
    logic signed [15:0] u_y;
    logic signed [15:0] v_x;
    logic signed [15:0] v_y;
  } obj_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_TEST,
    S_DONE
  } state_t;

  function automatic int IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Hit-pair FIFO: power-of-two ring buffer with registered storage; head is visible combinationally.
// Push is dropped when full and pop when empty, so callers must gate push on full_o.
module pair_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DAT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DAT_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [DAT_W-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DAT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/collision_scheduler.sv
// Sweeps all unordered object pairs through an external detector, 3 cycles per pair, queueing hits;
// stalls in TEST while a hit meets a full FIFO. COLL_SKIP_STATIC_EN skips pairs of two static objects.
module collision_scheduler
  import coll_pkg::*;
#(
  parameter int NUM_OBJ    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W(NUM_OBJ)-1:0]   rd_idx_a,
  output logic [IDX_W(NUM_OBJ)-1:0]   rd_idx_b,
  input  obj_t                        obj_a,
  input  obj_t                        obj_b,
  output obj_t                        det_a,
  output obj_t                        det_b,
  input  logic                        det_hit,
  output logic                        pair_valid,
  output logic [IDX_W(NUM_OBJ)-1:0]   pair_a,
  output logic [IDX_W(NUM_OBJ)-1:0]   pair_b,
  input  logic                        pair_ready,
  output logic [15:0]                 hit_count
);

  localparam int IW = IDX_W(NUM_OBJ);

  state_t          state_q;
  logic [IW-1:0]   i_q, j_q, i_d, j_d;
  logic            busy_q, done_q;
  obj_t            det_a_q, det_b_q;
  logic [15:0]     hit_cnt_q;

  logic            last_pair;
  logic            skip_pair;
  logic            stall;
  logic            advance;
  logic            push;
  logic            fifo_full, fifo_empty;
  logic [2*IW-1:0] head_dat;

  always_comb begin
    last_pair = (i_q == IW'(NUM_OBJ - 2)) && (j_q == IW'(NUM_OBJ - 1));
    if (j_q == IW'(NUM_OBJ - 1)) begin
      i_d = i_q + IW'(1);
      j_d = i_q + IW'(2);
    end else begin
      i_d = i_q;
      j_d = j_q + IW'(1);
    end
  end

  always_comb begin
    skip_pair = 1'b0;
`ifdef COLL_SKIP_STATIC_EN
    skip_pair = (state_q == S_LOAD) &&
                (obj_a.vel_x == '0) && (obj_a.vel_y == '0) &&
                (obj_b.vel_x == '0) && (obj_b.vel_y == '0);
`endif
  end

  // Full is judged on occupancy before any same-cycle pop.
  assign stall   = (state_q == S_TEST) && det_hit && fifo_full;
  assign push    = (state_q == S_TEST) && det_hit && !fifo_full;
  assign advance = ((state_q == S_TEST) && !stall) || skip_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= IW'(1);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_a_q   <= '0;
      det_b_q   <= '0;
      hit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            hit_cnt_q <= '0;
            i_q       <= '0;
            j_q       <= IW'(1);
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          if (skip_pair) begin
            state_q <= last_pair ? S_DONE : S_FETCH;
          end else begin
            det_a_q <= obj_a;
            det_b_q <= obj_b;
            state_q <= S_TEST;
          end
        end
        S_TEST: begin
          if (!stall) begin
            state_q <= last_pair ? S_DONE : S_FETCH;
            if (push && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Pair counter returns to (0,1) after the last pair so a new sweep starts clean.
      if (advance) begin
        if (last_pair) begin
          i_q    <= '0;
          j_q    <= IW'(1);
          done_q <= 1'b1;
        end else begin
          i_q <= i_d;
          j_q <= j_d;
        end
      end
    end
  end

  pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DAT_W      (2 * IW)
  ) u_pair_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i ({i_q, j_q}),
    .pop_i      (pair_ready),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_idx_a   = i_q;
  assign rd_idx_b   = j_q;
  assign det_a      = det_a_q;
  assign det_b      = det_b_q;
  assign hit_count  = hit_cnt_q;
  assign pair_valid = !fifo_empty;
  assign pair_a     = head_dat[2*IW-1:IW];
  assign pair_b     = head_dat[IW-1:0];

endmodule

// File: tb/tb_collision_scheduler.sv
// Random and directed sweeps checked against a pair-schedule/queue model of the scheduler.
module tb_collision_scheduler;
  import coll_pkg::*;

  localparam int N  = 8;
  localparam int FD = 4;
  localparam int IW = $clog2(N);
  localparam int P  = N * (N - 1) / 2;

  logic          clk, rst_n, start, busy, done, det_hit, pair_valid, pair_ready;
  logic [IW-1:0] rd_idx_a, rd_idx_b, pair_a, pair_b;
  obj_t          obj_a, obj_b, det_a, det_b;
  logic [15:0]   hit_count;

  obj_t tbl [N];
  int   pa [P];
  int   pb [P];

  int tests = 0, fails = 0;
  int pops = 0, pv_cycles = 0;
  logic [2*IW-1:0] last_pop;

  int   cyc = 0, t_next = 0, mk = 0, m_hits = 0;
  bit   m_busy = 0, m_done = 0;
  logic [2*IW-1:0] mq [$];

  collision_scheduler #(.NUM_OBJ(N), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b), .obj_a(obj_a), .obj_b(obj_b),
    .det_a(det_a), .det_b(det_b), .det_hit(det_hit),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b),
    .pair_ready(pair_ready), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object table with one-cycle read latency.
  always @(posedge clk) begin
    obj_a <= tbl[rd_idx_a];
    obj_b <= tbl[rd_idx_b];
  end

  // Reference detector: centred boxes overlap when centre distance < half the summed extents.
  function automatic bit coll(obj_t a, obj_t b);
    longint dx, dy, lx, ly;
    dx = longint'($signed(a.pos_x)) - longint'($signed(b.pos_x));
    dy = longint'($signed(a.pos_y)) - longint'($signed(b.pos_y));
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    lx = (longint'($signed(a.width))  + longint'($signed(b.width)))  * 64'sd8388608;
    ly = (longint'($signed(a.height)) + longint'($signed(b.height))) * 64'sd8388608;
    return (dx < lx) && (dy < ly);
  endfunction

  assign det_hit = coll(det_a, det_b);

`ifdef COLL_SKIP_STATIC_EN
  function automatic bit is_static(int k);
    return (tbl[pa[k]].vel_x == 0) && (tbl[pa[k]].vel_y == 0) &&
           (tbl[pb[k]].vel_x == 0) && (tbl[pb[k]].vel_y == 0);
  endfunction
`endif

  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Per-cycle compare against the model, then advance the model using this cycle's inputs.
  always @(negedge clk) begin : monitor
    bit pop, full, h, skipped;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_hits = 0; mq.delete();
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("hit_count", hit_count, m_hits);
    chk("pair_valid", pair_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("pair_a", pair_a, longint'(mq[0][2*IW-1:IW]));
      chk("pair_b", pair_b, longint'(mq[0][IW-1:0]));
    end
    if (!rst_n) begin
      chk("rst_det_a", det_a, 0);
      chk("rst_det_b", det_b, 0);
      chk("rst_rd_idx_a", rd_idx_a, 0);
      chk("rst_rd_idx_b", rd_idx_b, 1);
    end else begin
      if (m_busy && !m_done && cyc == t_next && mk < P) begin
        chk("det_a_operand", det_a == tbl[pa[mk]], 1);
        chk("det_b_operand", det_b == tbl[pb[mk]], 1);
      end
      if (pair_valid && pair_ready) begin
        pops++;
        last_pop = {pair_a, pair_b};
      end
      if (pair_valid) pv_cycles++;
      pop     = (mq.size() != 0) && pair_ready;
      full    = (mq.size() >= FD);
      skipped = 0;
      if (m_busy && m_done) begin
        m_busy = 0; m_done = 0;
      end else if (m_busy) begin
`ifdef COLL_SKIP_STATIC_EN
        if (cyc == t_next - 1 && is_static(mk)) begin
          skipped = 1;
          mk++;
          if (mk == P) m_done = 1; else t_next = cyc + 3;
        end
`endif
        if (!skipped && cyc == t_next) begin
          h = coll(tbl[pa[mk]], tbl[pb[mk]]);
          if (h && full) t_next = cyc + 1;
          else begin
            if (h) begin
              mq.push_back({IW'(pa[mk]), IW'(pb[mk])});
              if (m_hits < 65535) m_hits++;
            end
            mk++;
            if (mk == P) m_done = 1; else t_next = cyc + 3;
          end
        end
      end else if (start) begin
        m_busy = 1; m_hits = 0; mk = 0; t_next = cyc + 3;
      end
      if (pop) void'(mq.pop_front());
    end
    cyc++;
  end

  task automatic setup_base();
    for (int k = 0; k < N; k++) begin
      tbl[k]        = '0;
      tbl[k].width  = 8'sd10;
      tbl[k].height = 8'sd10;
      tbl[k].u_x    = 16'sh4000;
      tbl[k].v_y    = 16'sh4000;
      tbl[k].pos_x  = 32'(k) * 32'h2000_0000;
      tbl[k].pos_y  = 32'h0E00_0000;
      tbl[k].vel_x  = 24'sd1;
    end
  endtask

  task automatic setup_overlap(input bit moving);
    setup_base();
    for (int k = 0; k < N; k++) begin
      tbl[k].pos_x = 32'h0E00_0000;
      tbl[k].vel_x = moving ? 24'sd1 : 24'sd0;
    end
  endtask

  // start high in cycle 0; reports first done cycle and number of done pulses.
  task automatic sweep(input int s1, input int s2, output int dc, output int nd);
    dc = -1; nd = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 1; c < 3000; c++) begin
      @(posedge clk); #1 start = (c == s1) || (c == s2);
      @(negedge clk);
      if (done) begin nd++; if (dc < 0) dc = c; end
      if (dc >= 0 && c >= dc + 3) break;
    end
    start = 1'b0;
    if (dc < 0) begin
      tests++; fails++;
      $display("FAIL sweep_timeout: no done pulse within 3000 cycles");
    end
  endtask

  task automatic wait_idle_drained(input string nm);
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy && !pair_valid) break;
    end
    if (c >= 3000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy=%0d pair_valid=%0d", nm, busy, pair_valid);
    end
  endtask

  initial begin
    int dc, nd, p0, k, c;
    k = 0;
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++) begin pa[k] = i; pb[k] = j; k++; end
    rst_n = 1'b0; start = 1'b0; pair_ready = 1'b1;
    setup_base();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // No overlaps: done at 85, nothing queued.
    pv_cycles = 0;
    sweep(-1, -1, dc, nd);
    chk("t1_done_cycle", dc, 85);
    chk("t1_done_pulses", nd, 1);
    chk("t1_hit_count", hit_count, 0);
    chk("t1_valid_cycles", pv_cycles, 0);

    // Single overlap (0,1).
    setup_base();
    tbl[0].pos_x = 32'h0E00_0000;
    tbl[1].pos_x = 32'h1600_0000;
    p0 = pops;
    sweep(-1, -1, dc, nd);
    chk("t2_done_cycle", dc, 85);
    chk("t2_hit_count", hit_count, 1);
    chk("t2_pops", pops - p0, 1);
    chk("t2_pair", last_pop, {3'd0, 3'd1});

    // All overlap with consumer stalled: FIFO fills, FSM holds at (0,5).
    setup_overlap(1);
    pair_ready = 1'b0;
    p0 = pops;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t3_hold_idx_a", rd_idx_a, 0);
    chk("t3_hold_idx_b", rd_idx_b, 5);
    chk("t3_hold_busy", busy, 1);
    chk("t3_hold_hits", hit_count, 4);
    chk("t3_head", {pair_a, pair_b}, {3'd0, 3'd1});
    @(posedge clk); #1 pair_ready = 1'b1;
    nd = 0;
    for (c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (nd > 0 && !busy && !pair_valid) break;
    end
    chk("t3_drain_in_time", c < 1000, 1);
    chk("t3_pops", pops - p0, 28);
    chk("t3_hit_count", hit_count, 28);
    chk("t3_done_pulses", nd, 1);
    chk("t3_last_pair", last_pop, {3'd6, 3'd7});

    // Reset in TEST of (1,3), then a clean sweep.
    setup_overlap(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (26) @(posedge clk);
    @(negedge clk);
    chk("t4_pre_idx_a", rd_idx_a, 1);
    chk("t4_pre_idx_b", rd_idx_b, 3);
    chk("t4_pre_hits", hit_count, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_valid", pair_valid, 0);
    chk("t4_rst_hits", hit_count, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    setup_base();
    sweep(-1, -1, dc, nd);
    chk("t4_done_cycle", dc, 85);
    chk("t4_done_pulses", nd, 1);

    // Extra starts while busy are ignored.
    sweep(10, 40, dc, nd);
    chk("t5_done_cycle", dc, 85);
    chk("t5_done_pulses", nd, 1);

    // Static objects.
    setup_overlap(0);
    sweep(-1, -1, dc, nd);
`ifdef COLL_SKIP_STATIC_EN
    chk("t6_done_cycle", dc, 57);
    chk("t6_hit_count", hit_count, 0);
`else
    chk("t6_done_cycle", dc, 85);
    chk("t6_hit_count", hit_count, 28);
`endif
    wait_idle_drained("t6");

    // Randomized tables, consumer backpressure and stray start pulses.
    for (int it = 0; it < 8; it++) begin
      for (int q = 0; q < N; q++) begin
        tbl[q]        = '0;
        tbl[q].width  = 8'($urandom_range(4, 16));
        tbl[q].height = 8'($urandom_range(4, 16));
        tbl[q].pos_x  = 32'($urandom_range(0, 40)) << 24;
        tbl[q].pos_y  = 32'($urandom_range(0, 40)) << 24;
        tbl[q].vel_x  = 24'($urandom_range(0, 1));
      end
      for (c = 0; c < 3000; c++) begin
        @(posedge clk); #1;
        pair_ready = ($urandom_range(0, 2) != 0);
        start      = (c == 0) || ($urandom_range(0, 19) == 0);
        @(negedge clk);
        if (c > 2 && !busy) break;
      end
      start = 1'b0;
      pair_ready = 1'b1;
      if (c >= 3000) begin
        tests++; fails++;
        $display("FAIL rand_sweep_timeout: iteration %0d", it);
      end
      wait_idle_drained("rand");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
- REQ-001: Parameter NUM_OBJ, default 8, number of objects in the object table; SHALL be >= 2.
- REQ-002: Parameter FIFO_DEPTH, default 4, hit-pair FIFO entries; SHALL be a power of two >= 2.
- REQ-003: Clk  input  1  sole clock; one clock; all state SHALL be on the rising edge.
- REQ-004: Reset_n  input  1  reset is asynchronous and active-low.
- REQ-005: start  input  1  begin one sweep over all unordered pairs.
- REQ-006: busy  output  1  high whenever the FSM is not in IDLE.
- REQ-007: done  output  1  one-cycle pulse at end of sweep.
- REQ-008: rd_idx_a, rd_idx_b  output  $clog2(NUM_OBJ)  object-table read addresses.
- REQ-009: obj_a, obj_b  input  obj_t  table records, valid one cycle after their address.
- REQ-010: det_a, det_b  output  obj_t  registered operands to the collision_detector.
- REQ-011: det_hit  input  1  is_collision from the collision_detector, combinational on det_a/det_b.
- REQ-012: pair_valid, pair_a, pair_b  output  1/idx/idx  head of hit-pair FIFO.
- REQ-013: pair_ready  input  1  consumer pops the head when pair_valid && pair_ready.
- REQ-014: hit_count  output  16  hits in the current or last sweep.

Function
- REQ-015: Pairs (i,j), i<j, SHALL be enumerated lexicographically: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1); P = N(N-1)/2.
- REQ-016: FSM states IDLE, FETCH, LOAD, TEST, DONE; rd_idx_a=i and rd_idx_b=j are driven in every state.
- REQ-017: IDLE->FETCH on start; FETCH->LOAD unconditionally; in LOAD, det_a<=obj_a and det_b<=obj_b, then LOAD->TEST.
- REQ-018: TEST samples det_hit. If hit and FIFO full (count before any same-cycle pop), remain in TEST. Otherwise push (i,j) if hit, advance pair, go to FETCH, or to DONE after pair P-1.
- REQ-019: DONE drives done=1 for exactly one cycle, then goes to IDLE.
- REQ-020: Unstalled timing: start sampled in cycle 0 -> TEST of pair k in cycle 3k+3; done in cycle 3P+1 (85 for N=8).
- REQ-021: start SHALL be ignored while busy; a sweep cannot be restarted or aborted except by reset.
- REQ-022: On start acceptance, hit_count SHALL clear, then increment once per pushed hit, saturating at 16'hFFFF.
- REQ-023: The FIFO SHALL NOT be flushed by start; entries from a previous sweep remain in order.
- REQ-024: det_a/det_b SHALL hold their values outside LOAD.
- REQ-025: pair_valid SHALL be high iff the FIFO is non-empty; pair_a/pair_b are don't-care when it is empty.

Reset
- REQ-026: While Reset_n=0: state IDLE, i=0, j=1, FIFO empty; busy, done, and pair_valid are 0; hit_count, det_a, and det_b are 0.
- REQ-027: Reset asserted mid-sweep SHALL discard the sweep with no done pulse.

Configuration
- REQ-028: Macro COLL_SKIP_STATIC_EN, when defined: in LOAD, if both obj_a and obj_b have vel_x=vel_y=0, skip TEST and det register update, advance to the next FETCH (or DONE), and push no hit. A skipped pair costs 2 cycles.
- REQ-029: When COLL_SKIP_STATIC_EN is undefined, every pair SHALL be tested per REQ-017..020.

Structure
- REQ-030: Package coll_pkg SHALL hold obj_t. obj_t fields: width, height (8b signed); pos_x, pos_y (32b Q8.24 signed); vel_x, vel_y (24b signed); u_x, u_y, v_x, v_y (16b Q2.14 signed).
- REQ-031: coll_pkg SHALL also hold the FSM state enum and the IDX_W helper.
- REQ-032: The FIFO SHALL be the sub-module pair_fifo (parameter FIFO_DEPTH; push/pop/full/empty; registered storage).

Verification
- REQ-033: Setup: N=8, 10x10 objects, u=(0x4000,0), v=(0,0x4000), pos_x = k*0x20000000, pos_y=0x0E000000. Pulse start -> done in cycle 85, hit_count=0, pair_valid stays 0.
- REQ-034: Same setup, except obj1 pos_x=0x16000000 overlaps obj0 at 0x0E000000 -> exactly one entry (0,1); hit_count=1.
- REQ-035: All 8 objects at (0x0E000000,0x0E000000), pair_ready=0 -> 4 entries queued and the FSM holds in TEST for pair (0,5). Then raise pair_ready=1 -> 28 pops in lexicographic order; hit_count=28; done once.
- REQ-036: Reset_n pulsed low while in TEST of pair (1,3) -> immediately busy=0, pair_valid=0, hit_count=0. A subsequent start completes a full sweep at cycle 85.
- REQ-037: start pulsed again in cycles 10 and 40 of a sweep -> ignored; exactly one done pulse, in cycle 85.
- REQ-038: COLL_SKIP_STATIC_EN defined, all velocities 0, all objects overlapping -> done in cycle 57, hit_count=0. Macro undefined -> done in cycle 85, hit_count=28.
